// File: rtl/rwm_reader_if.sv
// Reader-side bundle: controller handshake, memory read port and byte stream to the consumer.
// The master modport is the reader; the slave modport is its environment.
interface rwm_reader_if #(
    parameter int unsigned ADDR_W = 16
);
    logic              RD_enable;
    logic              pause;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_rdata;
    logic [7:0]        Dout;
    logic              RWM_valid;
    logic              RD_done;

    modport master (
        input  RD_enable, pause, mem_rdata,
        output mem_rd_en, mem_addr, Dout, RWM_valid, RD_done
    );

    modport slave (
        output RD_enable, pause, mem_rdata,
        input  mem_rd_en, mem_addr, Dout, RWM_valid, RD_done
    );
endinterface

// File: rtl/rwm_reader.sv
// Streams one frame of bytes from a 1-cycle-latency memory to a pausable consumer,
// using an output register plus a skid register so reads never overrun the store.
module rwm_reader #(
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned BASE_ADDR   = 0,
    parameter int unsigned FRAME_BYTES = 1024
) (
    input  logic         clk,
    input  logic         rst_n,
    rwm_reader_if.master bus
);
    localparam int unsigned       CNT_W = ADDR_W + 1;
    localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(BASE_ADDR);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(FRAME_BYTES - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_issue_idx;
    logic [CNT_W-1:0]  r_sent_idx;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_inflight;
    logic [7:0]        r_dout;
    logic              r_valid;
    logic [7:0]        r_skid;
    logic              r_skid_vld;
    logic              r_rd_done;

    logic              w_transfer;
    logic [2:0]        w_occ;
    logic              w_issue;
    logic              w_last_issue;
    logic              w_last_xfer;
    logic              w_start;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state logic; RD_enable low aborts from any active state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (bus.RD_enable) w_state_nxt = S_RUN;
            S_RUN:   if (!bus.RD_enable) w_state_nxt = S_IDLE;
                     else if (w_last_issue) w_state_nxt = S_DRAIN;
            S_DRAIN: if (!bus.RD_enable) w_state_nxt = S_IDLE;
                     else if (w_last_xfer) w_state_nxt = S_DONE;
            S_DONE:  if (!bus.RD_enable) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Issue a read only if the store cannot overflow once it lands
    always_comb begin
        w_transfer   = 1'b0;
        w_occ        = 3'd0;
        w_issue      = 1'b0;
        w_last_issue = 1'b0;
        w_last_xfer  = 1'b0;
        w_start      = 1'b0;
        w_transfer   = r_valid & ~bus.pause;
        w_occ        = 3'(r_valid) + 3'(r_skid_vld) + 3'(r_inflight) - 3'(w_transfer);
        w_issue      = (r_state == S_RUN) && (w_occ < 3'd2);
        w_last_issue = w_issue && (r_issue_idx == LAST);
        w_last_xfer  = w_transfer && (r_sent_idx == LAST);
        w_start      = (r_state == S_IDLE) && bus.RD_enable;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_issue_idx <= '0;
            r_sent_idx  <= '0;
            r_mem_addr  <= BASE;
        end else if (w_start) begin
            r_issue_idx <= '0;
            r_sent_idx  <= '0;
            r_mem_addr  <= BASE;
        end else begin
            if (w_issue) begin
                r_issue_idx <= r_issue_idx + CNT_W'(1);
                r_mem_addr  <= r_mem_addr + ADDR_W'(1);
            end
            if (w_transfer) r_sent_idx <= r_sent_idx + CNT_W'(1);
        end
    end

    // Returning data fills the output register first, the skid register only while held
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inflight <= 1'b0;
            r_dout     <= 8'h00;
            r_valid    <= 1'b0;
            r_skid     <= 8'h00;
            r_skid_vld <= 1'b0;
        end else if (w_state_nxt == S_IDLE) begin
            r_inflight <= 1'b0;
            r_valid    <= 1'b0;
            r_skid_vld <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (!r_valid || w_transfer) begin
                if (r_skid_vld) begin
                    r_dout     <= r_skid;
                    r_valid    <= 1'b1;
                    r_skid_vld <= r_inflight;
                    if (r_inflight) r_skid <= bus.mem_rdata;
                end else begin
                    r_valid <= r_inflight;
                    if (r_inflight) r_dout <= bus.mem_rdata;
                end
            end else if (r_inflight) begin
                r_skid     <= bus.mem_rdata;
                r_skid_vld <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_rd_done <= 1'b0;
        else        r_rd_done <= (w_state_nxt == S_DONE);
    end

    assign bus.mem_rd_en = w_issue;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.Dout      = r_dout;
    assign bus.RWM_valid = r_valid;
    assign bus.RD_done   = r_rd_done;
endmodule

// File: doc/rwm_reader.md
RWM_READER -- requirements
Module: rwm_reader

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, memory address width.
REQ-002 SHALL have parameter BASE_ADDR, default 0, first byte address of the frame.
REQ-003 SHALL have parameter FRAME_BYTES, default 1024, bytes per frame (range 1 to 2^ADDR_W).
REQ-004 Ports (name, direction, width, meaning):
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  external asynchronous active-low reset.
- RD_enable  in  1  level from the controller; 1 = run a frame, 0 = idle or abort.
- pause  in  1  from the downstream consumer; 1 = hold the current byte.
- mem_rd_en  out  1  memory read strobe.
- mem_addr  out  ADDR_W  memory read address.
- mem_rdata  in  8  memory read data, valid exactly 1 cycle after the strobe.
- Dout  out  8  byte to the consumer.
- RWM_valid  out  1  Dout holds a valid byte.
- RD_done  out  1  frame complete status to the controller.
REQ-005 Clock is clk; reset is rst_n, asynchronous assert, active-low; no other clock or reset.

Function
REQ-006 SHALL implement the states IDLE, RUN, DRAIN and DONE.
REQ-007 IDLE->RUN when RD_enable=1 at a clock edge; on that edge issue-index and sent-index clear to 0.
REQ-008 RUN->DRAIN on the edge where the last read (issue-index = FRAME_BYTES-1) is issued.
REQ-009 DRAIN->DONE on the edge where the last byte transfers; DONE->IDLE when RD_enable=0.
REQ-010 Transfer definition: a transfer occurs on an edge where RWM_valid=1 and pause=0.
REQ-011 While pause=1 and RWM_valid=1, Dout SHALL stay stable.
REQ-012 Buffering: a 2-entry store (output register plus skid register).
- mem_rd_en=1 only in RUN, when (stored + in-flight - transfer-this-cycle) < 2.
- A 1-cycle memory latency SHALL never lose or duplicate a byte.
REQ-013 Address generation:
- mem_addr = (BASE_ADDR + issue-index) mod 2^ADDR_W; wraps silently at 2^ADDR_W.
- issue-index increments on each issued read and stops at FRAME_BYTES.
REQ-014 Ordering: bytes are delivered strictly in address order; exactly FRAME_BYTES transfers per frame.
REQ-015 Latency: the first read issues in the cycle after the IDLE->RUN edge; RWM_valid rises 2 edges after the IDLE->RUN edge.
REQ-016 Throughput: with pause=0, one transfer per cycle after the first byte.
REQ-017 On pause release, the held byte transfers first, then the skid byte on the next edge, with no gap.
REQ-018 RD_done=1 exactly while in DONE; RWM_valid=0 and mem_rd_en=0 in DONE and IDLE.
REQ-019 Abort: RD_enable=0 in RUN or DRAIN SHALL, on the next edge:
- go to IDLE;
- flush both buffer entries;
- discard any in-flight read;
- force RWM_valid=0;
- never assert RD_done.
REQ-020 RD_enable held at 1 in DONE SHALL NOT restart a frame; a new frame needs RD_enable low for at least 1 edge, then high.
REQ-021 FRAME_BYTES=1: RUN->DRAIN on the first issue edge; a single transfer follows, then DONE.

Reset
REQ-022 While rst_n=0, independent of clk:
- state=IDLE;
- indices=0;
- buffer entries empty.
REQ-023 Output reset values: mem_rd_en=0, mem_addr=BASE_ADDR, Dout=8'h00, RWM_valid=0, RD_done=0.
REQ-024 After rst_n deasserts, no action before the first edge with RD_enable=1.
REQ-025 Reset asserted mid-frame SHALL abandon the frame immediately, including any in-flight read.

Verification
REQ-026 Bench setup: FRAME_BYTES=8, BASE_ADDR=16'h0010, memory byte at address a = low 8 bits of a*3, clock period 20 ns.
REQ-027 Streaming: RD_enable=1, pause=0.
- RWM_valid rises 2 edges after enable.
- Dout sequence = 30,33,36,39,3C,3F,42,45 (hex) on consecutive edges.
- RD_done=1 on the next edge and stays 1 until RD_enable=0.
REQ-028 Backpressure: pause=1 for 5 cycles starting when Dout=36.
- Dout stays 36 throughout; mem_rd_en issues at most 1 extra read.
- After release, 36 then 39 transfer on consecutive edges; the full sequence is unchanged with no duplicates.
REQ-029 Random pause: 50% toggle per cycle.
- Exactly 8 transfers in address order.
- mem_rd_en never fires with 2 entries stored and no transfer.
REQ-030 Abort: RD_enable=0 after the 3rd transfer.
- Next edge: RWM_valid=0, state IDLE, RD_done stays 0.
- A re-enable restarts from Dout=30.
REQ-031 Reset mid-frame: rst_n=0 during DRAIN.
- All outputs take REQ-023 values immediately, without waiting for a clock edge.
- BASE_ADDR=16'hFFFE with FRAME_BYTES=4: addresses FFFE,FFFF,0000,0001.
